// File: rtl/helper_axis_pattern_generator.sv
// AXI-Stream stimulus master: counter, Galois-LFSR or constant data with periodic TLAST and valid throttling.
// Optional stall counter and hold-stability checker are enabled by defining HELPER_AXIS_GEN_STALL_STATS_EN.
module helper_axis_pattern_generator #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned MODE          = 0,
  parameter logic [31:0] START_AT      = 32'd0,
  parameter logic [31:0] STEP          = 32'd1,
  parameter logic [31:0] LFSR_SEED     = 32'h1,
  parameter int unsigned PACKET_LEN    = 16,
  parameter logic [31:0] TOTAL_BEATS   = 32'd0,
  parameter logic [7:0]  VALID_PATTERN = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_last,
  input  logic                  output_ready,
  output logic                  done,
  output logic [31:0]           beat_count,
  output logic [31:0]           stall_cycles
);

  localparam logic [31:0] EFF_SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] PKT_LEN_W = 32'(PACKET_LEN);
  localparam logic [31:0] PKT_LAST_IDX = PKT_LEN_W - 32'd1;
  localparam logic [DATA_WIDTH-1:0] RESET_DATA =
    (MODE == 32'd1) ? EFF_SEED[DATA_WIDTH-1:0] : START_AT[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] STEP_W = STEP[DATA_WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s[0]) begin
      return (s >> 1) ^ 32'h8020_0003;
    end else begin
      return s >> 1;
    end
  endfunction

  state_t                  state_r, state_s;
  logic [2:0]              ptr_r;
  logic [DATA_WIDTH-1:0]   data_r, data_s;
  logic [31:0]             lfsr_r, lfsr_s;
  logic [31:0]             beat_cnt_r, beat_cnt_s;
  logic [31:0]             pkt_idx_r, pkt_idx_s;
  logic                    valid_r, last_r, last_s, done_r;
  logic                    handshake_s, pattern_bit_s, limit_hit_s;

  // Next-state, next-data and frame-position logic.
  always_comb begin
    state_s       = state_r;
    data_s        = data_r;
    lfsr_s        = lfsr_r;
    beat_cnt_s    = beat_cnt_r;
    pkt_idx_s     = pkt_idx_r;
    handshake_s   = valid_r & output_ready;
    pattern_bit_s = VALID_PATTERN[ptr_r];
    limit_hit_s   = (TOTAL_BEATS != 32'd0) &&
                    (({1'b0, beat_cnt_r} + 33'd1) == {1'b0, TOTAL_BEATS});

    case (state_r)
      ST_IDLE: begin
        if (enable && pattern_bit_s) begin
          state_s = ST_OFFER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (!handshake_s) begin
          state_s = ST_OFFER;
        end else if (limit_hit_s) begin
          state_s = ST_DONE;
        end else if (enable && pattern_bit_s) begin
          state_s = ST_OFFER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (handshake_s) begin
      case (MODE)
        32'd0: begin
          data_s = data_r + STEP_W;
        end
        32'd1: begin
          lfsr_s = lfsr_step(lfsr_r);
          data_s = lfsr_s[DATA_WIDTH-1:0];
        end
        default: begin
          data_s = data_r;
        end
      endcase
      if (beat_cnt_r != 32'hFFFF_FFFF) begin
        beat_cnt_s = beat_cnt_r + 32'd1;
      end else begin
        beat_cnt_s = beat_cnt_r;
      end
      if ((PKT_LEN_W == 32'd0) || (pkt_idx_r == PKT_LAST_IDX)) begin
        pkt_idx_s = 32'd0;
      end else begin
        pkt_idx_s = pkt_idx_r + 32'd1;
      end
    end else begin
      data_s = data_r;
    end

    // TLAST is only ever shown alongside a valid beat.
    last_s = (state_s == ST_OFFER) && (PKT_LEN_W != 32'd0) && (pkt_idx_s == PKT_LAST_IDX);
  end

  // State, datapath and registered AXIS outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 3'd0;
      data_r     <= RESET_DATA;
      lfsr_r     <= EFF_SEED;
      beat_cnt_r <= 32'd0;
      pkt_idx_r  <= 32'd0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_r + 3'd1;
      data_r     <= data_s;
      lfsr_r     <= lfsr_s;
      beat_cnt_r <= beat_cnt_s;
      pkt_idx_r  <= pkt_idx_s;
      valid_r    <= (state_s == ST_OFFER);
      last_r     <= last_s;
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign output_valid = valid_r;
  assign output_data  = data_r;
  assign output_last  = last_r;
  assign done         = done_r;
  assign beat_count   = beat_cnt_r;

`ifdef HELPER_AXIS_GEN_STALL_STATS_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of back-pressured cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if (valid_r && !output_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;

  helper_axis_pattern_generator_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .output_valid (valid_r),
    .output_ready (output_ready),
    .output_data  (data_r),
    .output_last  (last_r)
  );
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

`ifdef HELPER_AXIS_GEN_STALL_STATS_EN
// Simulation checker: payload must not change while a beat is back-pressured.
module helper_axis_pattern_generator_chk #(
  parameter int unsigned DATA_WIDTH = 10
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  output_valid,
  input logic                  output_ready,
  input logic [DATA_WIDTH-1:0] output_data,
  input logic                  output_last
);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (output_valid && !output_ready) |=> ($stable(output_data) && $stable(output_last)));

endmodule
`endif

// File: tb/tb_helper_axis_pattern_generator.sv
// Scoreboard bench for helper_axis_pattern_generator: counter instance (framing, stall, done, async reset)
// and LFSR instance (throttle pattern, random back-pressure, restart after reset).
`timescale 1ns/1ps
module tb_helper_axis_pattern_generator;

  localparam int A_DW = 4, A_START = 5, A_STEP = 3, A_PL = 4, A_TOTAL = 10;
  localparam int B_DW = 8, B_PL = 3;
`ifdef HELPER_AXIS_GEN_STALL_STATS_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rdy_a, va, la, done_a;
  logic [A_DW-1:0] da;
  logic [31:0] bca, sca;
  logic rst_b, en_b, rdy_b, vb, lb, done_b;
  logic [B_DW-1:0] db;
  logic [31:0] bcb, scb;

  helper_axis_pattern_generator #(
    .DATA_WIDTH(A_DW), .MODE(0), .START_AT(32'd5), .STEP(32'd3), .LFSR_SEED(32'h1),
    .PACKET_LEN(A_PL), .TOTAL_BEATS(32'd10), .VALID_PATTERN(8'hFF)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .output_valid(va), .output_data(da),
    .output_last(la), .output_ready(rdy_a), .done(done_a), .beat_count(bca), .stall_cycles(sca)
  );

  helper_axis_pattern_generator #(
    .DATA_WIDTH(B_DW), .MODE(1), .START_AT(32'd0), .STEP(32'd1), .LFSR_SEED(32'h0),
    .PACKET_LEN(B_PL), .TOTAL_BEATS(32'd0), .VALID_PATTERN(8'b0101_0101)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .output_valid(vb), .output_data(db),
    .output_last(lb), .output_ready(rdy_b), .done(done_b), .beat_count(bcb), .stall_cycles(scb)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [31:0] idx;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Beat k of the counter stream: arithmetic progression modulo 2^A_DW.
  function automatic beat_t model_a(input int k);
    beat_t b;
    b.data = 32'((A_START + k * A_STEP) % (1 << A_DW));
    b.last = ((k % A_PL) == (A_PL - 1));
    b.idx  = 32'(k);
    return b;
  endfunction

  // Beat k of the LFSR stream: seed 0 becomes 1, then k steps of the Galois LFSR.
  function automatic beat_t model_b(input int k);
    beat_t b;
    logic [31:0] s;
    logic [31:0] taps;
    int ex[4] = '{32, 22, 2, 1};
    taps = 32'd0;
    foreach (ex[i]) taps[ex[i] - 1] = 1'b1;
    s = 32'd1;
    for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    b.data = {24'd0, s[7:0]};
    b.last = ((k % B_PL) == (B_PL - 1));
    b.idx  = 32'(k);
    return b;
  endfunction

  task automatic fill_a();
    qa.delete();
    for (int k = 0; k < A_TOTAL; k++) qa.push_back(model_a(k));
  endtask

  task automatic fill_b(input int n);
    qb.delete();
    for (int k = 0; k < n; k++) qb.push_back(model_b(k));
  endtask

  // Monitor A: scoreboard pop on handshake plus no-retract/hold checks.
  logic hold_a = 1'b0;
  logic [A_DW-1:0] hd_a;
  logic hl_a;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_a) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        chk("a_hold_valid", {31'd0, va}, 32'd1);
        chk("a_hold_data", {28'd0, da}, {28'd0, hd_a});
        chk("a_hold_last", {31'd0, la}, {31'd0, hl_a});
      end
      if (va && rdy_a) begin
        if (qa.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected_beat: got beat data %0h, expected no beat", da);
        end else begin
          e = qa.pop_front();
          chk("a_data", {28'd0, da}, e.data);
          chk("a_last", {31'd0, la}, {31'd0, e.last});
          chk("a_beat_count", bca, e.idx);
        end
      end
      hold_a = va && !rdy_a;
      hd_a = da;
      hl_a = la;
    end
  end

  // Monitor B: same scoreboard discipline for the LFSR stream.
  logic hold_b = 1'b0;
  logic [B_DW-1:0] hd_b;
  logic hl_b;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_b) begin
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        chk("b_hold_valid", {31'd0, vb}, 32'd1);
        chk("b_hold_data", {24'd0, db}, {24'd0, hd_b});
        chk("b_hold_last", {31'd0, lb}, {31'd0, hl_b});
      end
      if (vb && rdy_b) begin
        if (qb.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected_beat: got beat data %0h, expected no beat", db);
        end else begin
          e = qb.pop_front();
          chk("b_data", {24'd0, db}, e.data);
          chk("b_last", {31'd0, lb}, {31'd0, e.last});
          chk("b_beat_count", bcb, e.idx);
        end
      end
      hold_b = vb && !rdy_b;
      hd_b = db;
      hl_b = lb;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_a = 1'b0; en_a = 1'b0; rdy_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_valid", {31'd0, va}, 32'd0);
    chk("a_rst_last", {31'd0, la}, 32'd0);
    chk("a_rst_done", {31'd0, done_a}, 32'd0);
    chk("a_rst_count", bca, 32'd0);
    chk("a_rst_stall", sca, 32'd0);
    chk("a_rst_data", {28'd0, da}, 32'd5);
    chk("b_rst_valid", {31'd0, vb}, 32'd0);
    chk("b_rst_data", {24'd0, db}, 32'd1);

    // Counter stream: latency, stall with enable dropped, then run to done.
    fill_a();
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("a_idle_without_enable", {31'd0, va}, 32'd0);
    en_a = 1'b1;
    @(posedge clk); #1;
    chk("a_enable_latency", {31'd0, va}, 32'd1);
    chk("a_first_data", {28'd0, da}, 32'd5);
    rdy_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy_a = 1'b0; en_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_stall_valid", {31'd0, va}, 32'd1);
    chk("a_stall_data", {28'd0, da}, model_a(3).data);
    chk("a_stall_last", {31'd0, la}, 32'd1);
    chk("a_stall_cycles", sca, 32'(2 * STALL_ON));
    rdy_a = 1'b1;
    @(posedge clk); #1;
    chk("a_idle_after_enable_drop", {31'd0, va}, 32'd0);
    chk("a_count_after_stall", bca, 32'd4);
    en_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_a) break;
    end
    chk("a_done", {31'd0, done_a}, 32'd1);
    chk("a_done_count", bca, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    chk("a_done_valid_low", {31'd0, va}, 32'd0);
    chk("a_done_sticky", {31'd0, done_a}, 32'd1);
    chk("a_all_beats_seen", 32'(qa.size()), 32'd0);
    chk("a_stall_total", sca, 32'(2 * STALL_ON));

    // Asynchronous reset while done is high.
    @(posedge clk); #3;
    rst_a = 1'b0;
    #1;
    chk("a_async_done", {31'd0, done_a}, 32'd0);
    chk("a_async_count", bca, 32'd0);
    chk("a_async_stall", sca, 32'd0);

    // Asynchronous reset while a TLAST beat is being offered.
    @(posedge clk); #1;
    fill_a();
    rdy_a = 1'b0;
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (va) break;
    end
    chk("a_restart_valid", {31'd0, va}, 32'd1);
    rdy_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy_a = 1'b0;
    chk("a_pre_reset_last", {31'd0, la}, 32'd1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_async_valid", {31'd0, va}, 32'd0);
    chk("a_async_last", {31'd0, la}, 32'd0);
    chk("a_async_data", {28'd0, da}, 32'd5);
    qa.delete();
    en_a = 1'b0;

    // LFSR stream: throttle rate with ready held high.
    fill_b(120);
    rst_b = 1'b1; en_b = 1'b1; rdy_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (vb) break;
    end
    chk("b_valid_seen", {31'd0, vb}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (vb) cnt++;
    end
    chk("b_pattern_rate", 32'(cnt), 32'd16);

    // Random back-pressure.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      rdy_b = 1'($urandom_range(0, 1));
    end
    rdy_b = 1'b1;

    // Reset mid-run restarts the LFSR from the effective seed.
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    chk("b_async_valid", {31'd0, vb}, 32'd0);
    chk("b_async_data", {24'd0, db}, 32'd1);
    @(posedge clk); #1;
    fill_b(40);
    rst_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (vb) break;
    end
    chk("b_restart_first_word", {24'd0, db}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rdy_b = 1'($urandom_range(0, 1));
    end
    rdy_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("b_count_matches_scoreboard", bcb, 32'(40 - qb.size()));
    chk("b_never_done", {31'd0, done_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
